// File: rtl/mult_hilo_if.sv
// Request/result bundle between ALU control and the HI/LO multiply unit.
// master = issuing pipeline side, slave = mult_hilo_unit.
interface mult_hilo_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, rd_sel,
    input  rd_data, busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, rd_sel,
    output rd_data, busy, done, hi, lo
  );
endinterface

// File: rtl/mult_hilo_unit.sv
// Sequential shift-add unsigned multiplier committing into HI/LO (multu, maddu).
// Define MULT_MADDU_EN to build the maddu accumulate path; otherwise only multu is accepted.
module mult_hilo_unit #(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] OP_MULTU = 4'b1010,
  parameter logic [3:0] OP_MADDU = 4'b1011
) (
  input logic       clk,
  input logic       rst,
  mult_hilo_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, COMMIT} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand, mplier, hi, lo;
  logic [2*WIDTH:0]   prod;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     sum;
  logic               done_q, op_ok, accept, last;
`ifdef MULT_MADDU_EN
  logic               acc;
`endif

  always_comb begin
    op_ok = (bus.op == OP_MULTU);
`ifdef MULT_MADDU_EN
    op_ok = op_ok | (bus.op == OP_MADDU);
`endif
  end

  assign accept = bus.start && op_ok && (state == IDLE);
  assign last   = (cnt == CW'(WIDTH - 1));
  // Top WIDTH+1 bits of the partial product absorb the adder carry.
  assign sum    = prod[2*WIDTH:WIDTH] + (mplier[0] ? {1'b0, mcand} : '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      done_q <= 1'b0;
`ifdef MULT_MADDU_EN
      acc    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          mcand  <= bus.a;
          mplier <= bus.b;
          prod   <= '0;
          cnt    <= '0;
`ifdef MULT_MADDU_EN
          acc    <= (bus.op == OP_MADDU);
`endif
        end
        RUN: begin
          prod   <= {1'b0, sum, prod[WIDTH-1:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        COMMIT: begin
`ifdef MULT_MADDU_EN
          if (acc) {hi, lo} <= {hi, lo} + prod[2*WIDTH-1:0];
          else     {hi, lo} <= prod[2*WIDTH-1:0];
`else
          {hi, lo} <= prod[2*WIDTH-1:0];
`endif
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.hi      = hi;
  assign bus.lo      = lo;
  assign bus.rd_data = bus.rd_sel ? hi : lo;
endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit: vector table plus busy-ignore, abort, reset/start and back-to-back sequences.
module tb_mult_hilo_unit;
  localparam int         W     = 32;
  localparam logic [3:0] MULTU = 4'b1010;
  localparam logic [3:0] MADDU = 4'b1011;
  localparam logic [3:0] BADOP = 4'b0010;
`ifdef MULT_MADDU_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_hilo_if #(.WIDTH(W)) bus ();

  mult_hilo_unit #(.WIDTH(W), .OP_MULTU(MULTU), .OP_MADDU(MADDU)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Returns cycles after the current point until done is seen, 0 if never within limit.
  task automatic wait_done(input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        n = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          exp_done;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n;
    bus.start  = 1'b0;
    bus.op     = '0;
    bus.a      = '0;
    bus.b      = '0;
    bus.rd_sel = 1'b0;
    rst        = 1'b1;

    vecs[0] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{MULTU, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000000, 32'hFFFFFFFF};
    vecs[2] = '{MULTU, 32'h80000000, 32'h00000002, 1'b1, 32'h00000001, 32'h00000000};
    vecs[3] = '{MULTU, 32'h00000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000000};
    vecs[4] = '{MULTU, 32'h00000007, 32'h00000006, 1'b1, 32'h00000000, 32'h0000002A};
    vecs[5] = '{MADDU, 32'h00010000, 32'h00010000, MADD,
                MADD ? 32'h00000001 : 32'h00000000, 32'h0000002A};
    vecs[6] = '{BADOP, 32'h00000005, 32'h00000005, 1'b0,
                MADD ? 32'h00000001 : 32'h00000000, 32'h0000002A};
    vecs[7] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001};
    vecs[8] = '{MADDU, 32'h00000002, 32'hFFFFFFFF, MADD,
                MADD ? 32'hFFFFFFFF : 32'hFFFFFFFE, MADD ? 32'hFFFFFFFF : 32'h00000001};
    vecs[9] = '{MADDU, 32'h00000001, 32'h00000001, MADD,
                MADD ? 32'h00000000 : 32'hFFFFFFFE, MADD ? 32'h00000000 : 32'h00000001};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_rd", bus.rd_data, 0);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_busy", i), bus.busy, vecs[i].exp_done);
      wait_done(40, n);
      chk($sformatf("v%0d_lat", i), n, vecs[i].exp_done ? 33 : 0);
      chk($sformatf("v%0d_hi", i), bus.hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), bus.lo, vecs[i].lo);
      bus.rd_sel = 1'b1; #1;
      chk($sformatf("v%0d_rdhi", i), bus.rd_data, vecs[i].hi);
      bus.rd_sel = 1'b0; #1;
      chk($sformatf("v%0d_rdlo", i), bus.rd_data, vecs[i].lo);
      if (vecs[i].exp_done) begin
        @(posedge clk); #1;
        chk($sformatf("v%0d_pulse", i), bus.done, 0);
      end
    end

    // start while busy must not restart or re-latch
    issue(MULTU, 32'd3, 32'd5);
    repeat (9) begin @(posedge clk); #1; end
    bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(40, n);
    chk("busy_ign_lat", n + 10, 33);
    chk("busy_ign_hi", bus.hi, 0);
    chk("busy_ign_lo", bus.lo, 15);
    wait_done(40, n);
    chk("busy_ign_nodone", n, 0);

    // reset mid-operation aborts without commit
    issue(MULTU, 32'h12345678, 32'h9ABCDEF0);
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_hi", bus.hi, 0);
    chk("abort_lo", bus.lo, 0);
    wait_done(40, n);
    chk("abort_nodone", n, 0);
    issue(MULTU, 32'd2, 32'd3);
    wait_done(40, n);
    chk("post_abort_lat", n, 33);
    chk("post_abort_lo", bus.lo, 6);
    chk("post_abort_hi", bus.hi, 0);

    // start coincident with reset is dropped
    rst = 1'b1;
    bus.op = MULTU; bus.a = 32'd4; bus.b = 32'd4; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; rst = 1'b0;
    chk("rst_start_busy", bus.busy, 0);
    chk("rst_start_lo", bus.lo, 0);
    @(posedge clk); #1;
    chk("rst_start_busy2", bus.busy, 0);
    chk("rst_start_done", bus.done, 0);

    // new start accepted in the done cycle
    issue(MULTU, 32'd4, 32'd5);
    wait_done(40, n);
    chk("b2b_lat0", n, 33);
    chk("b2b_lo0", bus.lo, 20);
    issue(MULTU, 32'd6, 32'd7);
    chk("b2b_busy", bus.busy, 1);
    wait_done(40, n);
    chk("b2b_lat1", n, 33);
    chk("b2b_lo1", bus.lo, 42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
